neuron_requant_relu: RTL and testbench
======================================

Name: neuron_requant_relu

Overview:
- Downstream stage of the int8 MAC neuron: consumes the neuron's signed 20-bit accumulated dot-product and converts it back to int8 activations.
- Per result: add bias, multiply by fixed-point scale, round-shift, saturate to int8, optional ReLU.
- Buffers results in a small first-word-fall-through FIFO behind a valid/ready output handshake, so the next layer can stall without stalling the neuron.
- The neuron cannot be back-pressured; an overflowing result is dropped and flagged.

Parameters:
- ACC_W, 20, width of the incoming signed accumulated sum and of bias.
- SCALE_W, 16, width of the unsigned scale multiplier.
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- sum_valid  input  1  accumulated_sum holds a finished dot-product this cycle
- accumulated_sum  input  ACC_W  signed neuron result
- bias  input  ACC_W  signed bias; sampled with sum_valid
- scale  input  SCALE_W  unsigned multiplier; sampled with sum_valid
- shift  input  5  right-shift amount 0..31; sampled with sum_valid
- relu_en  input  1  1 = clamp negatives to 0; sampled with sum_valid
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head when out_valid & out_ready
- out_data  output  8  signed int8 activation at FIFO head
- ovf  output  1  sticky: a result was dropped because the FIFO was full
- sat_cnt  output  16  saturating count of results clipped to int8 range
- clr_flags  input  1  synchronous clear of ovf and sat_cnt

Behaviour:
- Reset: all pipeline valid bits 0, FIFO empty, out_valid=0, out_data=0, ovf=0, sat_cnt=0. Reset mid-operation discards all in-flight and buffered results.
- Pipeline stages (3 registered stages, each with a valid bit). No stalls; one result may enter every cycle.
- S1 (edge where sum_valid=1): b = accumulated_sum + bias, ACC_W+1 bits signed. Capture scale, shift and relu_en alongside b, so config changes never affect results already in flight.
- S2: p = b * {1'b0, scale}, signed, ACC_W+SCALE_W+2 bits, exact with no overflow.
- S3:
  - r = (p + (shift>0 ? 2^(shift-1) : 0)) >>> shift, arithmetic shift (round half toward +inf).
  - Saturate r to [-128, 127]; the result counts as saturated if clipping occurred.
  - If relu_en and the value is negative, output 0. A ReLU clamp is not counted as saturation.
- FIFO write at the S3 edge, 3 cycles after the sum_valid edge.
  - FWFT: out_valid rises in the same cycle the entry is written into an empty FIFO, and out_data is valid with it.
- Pop occurs on a clock edge with out_valid & out_ready. out_data holds stable while out_valid=1 and out_ready=0.
- Full FIFO with a simultaneous write and pop: both occur and nothing is dropped.
- Full FIFO with a write and no pop: the new result is dropped, FIFO contents are unchanged, ovf is set.
- Empty FIFO: out_valid=0. out_ready is ignored and pointers do not move.
- Pointers are log2(FIFO_DEPTH) bits plus a wrap bit for full/empty; both wrap modulo depth.
- sat_cnt increments once per saturated result that is written or dropped, and holds at 16'hFFFF.
- clr_flags clears ovf and sat_cnt. If clr_flags coincides with a new event, clear wins for that cycle; the event is lost.
- Throughput 1 result/cycle sustained when out_ready is held high.

Test Plan:
- Pass-through: scale=1, shift=0, bias=0, relu_en=0, sum=100, out_ready=1 -> out_valid 3 cycles after sum_valid, out_data=100, sat_cnt=0.
- Bias/scale/round: sum=100, bias=-30, scale=3, shift=2 -> (210+2)>>>2 = 53. sum=5, scale=1, shift=1 -> 3. sum=-5, scale=1, shift=1 -> -2.
- Saturation/ReLU:
  - sum=1000, scale=1, shift=0 -> 127, sat_cnt=1.
  - sum=-1000 -> -128, sat_cnt=2.
  - sum=-50 with relu_en=1 -> 0, sat_cnt unchanged.
  - sum=-50 with relu_en=0 -> -50 (0xCE).
- Back-pressure/overflow, FIFO_DEPTH=4, out_ready=0:
  - Send 6 back-to-back results 1..6 -> 4 stored, ovf=1.
  - Then raise out_ready -> out_data sequence 1,2,3,4, after which out_valid=0.
- Full + simultaneous: FIFO full, out_ready=1 on the same edge as a new write -> no drop, ovf stays 0, order preserved.
- Reset mid-flight: assert rst with 2 results in the pipeline and 3 in the FIFO -> out_valid=0, ovf=0, sat_cnt=0 immediately. After release, no stale output appears.

Source files
------------

// File: rtl/neuron_requant_relu.sv
// neuron_requant_relu: requantises the neuron's signed accumulated sum back to
// int8 (bias add, fixed-point scale, round-shift, saturate, optional ReLU) and
// buffers the activations in a first-word-fall-through FIFO with a
// valid/ready output. The neuron side is never stalled, so a result arriving
// at a full FIFO (with no pop on that edge) is dropped and flagged in ovf.
module neuron_requant_relu #(
    parameter int ACC_W      = 20,
    parameter int SCALE_W    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sum_valid,
    input  logic [ACC_W-1:0]   accumulated_sum,
    input  logic [ACC_W-1:0]   bias,
    input  logic [SCALE_W-1:0] scale,
    input  logic [4:0]         shift,
    input  logic               relu_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               ovf,
    output logic [15:0]        sat_cnt,
    input  logic               clr_flags
);

    localparam int B_W   = ACC_W + 1;
    localparam int P_W   = ACC_W + SCALE_W + 2;
    // One guard bit above the product so adding the rounding term never wraps.
    localparam int R_W   = P_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic signed [R_W-1:0] SAT_MAX = R_W'(127);
    localparam logic signed [R_W-1:0] SAT_MIN = -R_W'(128);

    // Stage 1: bias added, config captured with the data
    logic                    s1_valid_q, s1_valid_d;
    logic signed [B_W-1:0]   s1_b_q, s1_b_d;
    logic [SCALE_W-1:0]      s1_scale_q, s1_scale_d;
    logic [4:0]              s1_shift_q, s1_shift_d;
    logic                    s1_relu_q, s1_relu_d;

    // Stage 2: exact product
    logic                    s2_valid_q, s2_valid_d;
    logic signed [P_W-1:0]   s2_p_q, s2_p_d;
    logic [4:0]              s2_shift_q, s2_shift_d;
    logic                    s2_relu_q, s2_relu_d;

    // Stage 3 (combinational from stage 2, lands in the FIFO)
    logic signed [R_W-1:0]   s3_half;
    logic signed [R_W-1:0]   s3_round;
    logic signed [R_W-1:0]   s3_shifted;
    logic [7:0]              s3_result;
    logic                    s3_clipped;

    // FIFO
    logic [7:0]              fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]          rd_ptr_q, rd_ptr_d;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    fifo_pop;
    logic                    fifo_wr;
    logic                    fifo_drop;

    // Flags
    logic                    ovf_q, ovf_d;
    logic [15:0]             sat_cnt_q, sat_cnt_d;

    // Round, shift, saturate and ReLU the stage-2 product.
    always_comb begin
        s3_half = '0;
        if (s2_shift_q != 5'd0) begin
            s3_half = R_W'(1) << (s2_shift_q - 5'd1);
        end
        s3_round   = {s2_p_q[P_W-1], s2_p_q} + s3_half;
        s3_shifted = s3_round >>> s2_shift_q;
        s3_clipped = 1'b0;
        s3_result  = s3_shifted[7:0];
        if (s3_shifted > SAT_MAX) begin
            s3_result  = 8'h7F;
            s3_clipped = 1'b1;
        end else if (s3_shifted < SAT_MIN) begin
            s3_result  = 8'h80;
            s3_clipped = 1'b1;
        end
        // ReLU applies after saturation and is not itself a clip.
        if (s2_relu_q && s3_result[7]) begin
            s3_result = 8'h00;
        end
    end

    // FIFO status and handshake decisions.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        fifo_pop   = !fifo_empty && out_ready;
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        fifo_wr    = s2_valid_q && (!fifo_full || fifo_pop);
        fifo_drop  = s2_valid_q && fifo_full && !fifo_pop;
    end

    // Next-state for pipeline registers, pointers and flags.
    always_comb begin
        s1_valid_d = sum_valid;
        s1_b_d     = s1_b_q;
        s1_scale_d = s1_scale_q;
        s1_shift_d = s1_shift_q;
        s1_relu_d  = s1_relu_q;
        if (sum_valid) begin
            s1_b_d     = B_W'($signed(accumulated_sum)) + B_W'($signed(bias));
            s1_scale_d = scale;
            s1_shift_d = shift;
            s1_relu_d  = relu_en;
        end

        s2_valid_d = s1_valid_q;
        s2_p_d     = s2_p_q;
        s2_shift_d = s2_shift_q;
        s2_relu_d  = s2_relu_q;
        if (s1_valid_q) begin
            s2_p_d     = P_W'(s1_b_q) * P_W'($signed({1'b0, s1_scale_q}));
            s2_shift_d = s1_shift_q;
            s2_relu_d  = s1_relu_q;
        end

        wr_ptr_d = fifo_wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = fifo_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        // Clear has priority over any event in the same cycle.
        ovf_d     = ovf_q;
        sat_cnt_d = sat_cnt_q;
        if (clr_flags) begin
            ovf_d     = 1'b0;
            sat_cnt_d = '0;
        end else begin
            if (fifo_drop) begin
                ovf_d = 1'b1;
            end
            if (s2_valid_q && s3_clipped && (sat_cnt_q != 16'hFFFF)) begin
                sat_cnt_d = sat_cnt_q + 16'd1;
            end
        end
    end

    // State registers; reset discards everything in flight or buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_b_q     <= '0;
            s1_scale_q <= '0;
            s1_shift_q <= '0;
            s1_relu_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_p_q     <= '0;
            s2_shift_q <= '0;
            s2_relu_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_b_q     <= s1_b_d;
            s1_scale_q <= s1_scale_d;
            s1_shift_q <= s1_shift_d;
            s1_relu_q  <= s1_relu_d;
            s2_valid_q <= s2_valid_d;
            s2_p_q     <= s2_p_d;
            s2_shift_q <= s2_shift_d;
            s2_relu_q  <= s2_relu_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    // FIFO storage; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= s3_result;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign ovf       = ovf_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_neuron_requant_relu.sv
// Directed bench for neuron_requant_relu: arithmetic vectors, saturation and
// ReLU, back-pressure overflow, full-FIFO simultaneous write/pop, and reset
// in the middle of traffic. Inputs change and outputs are sampled on the
// falling edge; the design acts on the rising edge.
module tb_neuron_requant_relu;

    logic        clk = 1'b0;
    logic        rst;
    logic        sum_valid;
    logic [19:0] accumulated_sum;
    logic [19:0] bias;
    logic [15:0] scale;
    logic [4:0]  shift;
    logic        relu_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        ovf;
    logic [15:0] sat_cnt;
    logic        clr_flags;

    int pass_cnt  = 0;
    int check_cnt = 0;

    neuron_requant_relu #(
        .ACC_W(20), .SCALE_W(16), .FIFO_DEPTH(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sum_valid       (sum_valid),
        .accumulated_sum (accumulated_sum),
        .bias            (bias),
        .scale           (scale),
        .shift           (shift),
        .relu_en         (relu_en),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .ovf             (ovf),
        .sat_cnt         (sat_cnt),
        .clr_flags       (clr_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_in(input logic signed [19:0] s, input logic signed [19:0] b,
                          input logic [15:0] sc, input logic [4:0] sh, input logic r);
        sum_valid       = 1'b1;
        accumulated_sum = s;
        bias            = b;
        scale           = sc;
        shift           = sh;
        relu_en         = r;
    endtask

    // One isolated result with out_ready high: check latency, value, sat_cnt, pop.
    task automatic run1(input string tag, input logic signed [19:0] s, input logic signed [19:0] b,
                        input logic [15:0] sc, input logic [4:0] sh, input logic r,
                        input logic [7:0] exp_data, input logic [15:0] exp_sat);
        set_in(s, b, sc, sh, r);
        step();
        sum_valid = 1'b0;
        step();
        chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(exp_data));
        chk({tag, "_sat"}, 32'(sat_cnt), 32'(exp_sat));
        $display("txn %s: out_data=0x%02h sat_cnt=%0d", tag, out_data, sat_cnt);
        step();
        chk({tag, "_popped"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        sum_valid = 1'b0;
        accumulated_sum = '0;
        bias = '0;
        scale = '0;
        shift = '0;
        relu_en = 1'b0;
        out_ready = 1'b1;
        clr_flags = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_sat", 32'(sat_cnt), 32'd0);
        rst = 1'b0;
        step();

        // Arithmetic, rounding, saturation and ReLU vectors.
        run1("pass",    20'sd100,   20'sd0,   16'd1, 5'd0, 1'b0, 8'h64, 16'd0);
        run1("bias_sc", 20'sd100,  -20'sd30,  16'd3, 5'd2, 1'b0, 8'h35, 16'd0);
        run1("rnd_pos", 20'sd5,     20'sd0,   16'd1, 5'd1, 1'b0, 8'h03, 16'd0);
        run1("rnd_neg", -20'sd5,    20'sd0,   16'd1, 5'd1, 1'b0, 8'hFE, 16'd0);
        run1("sat_hi",  20'sd1000,  20'sd0,   16'd1, 5'd0, 1'b0, 8'h7F, 16'd1);
        run1("sat_lo",  -20'sd1000, 20'sd0,   16'd1, 5'd0, 1'b0, 8'h80, 16'd2);
        run1("relu",    -20'sd50,   20'sd0,   16'd1, 5'd0, 1'b1, 8'h00, 16'd2);
        run1("norelu",  -20'sd50,   20'sd0,   16'd1, 5'd0, 1'b0, 8'hCE, 16'd2);

        // Back-pressure: six results into a 4-deep FIFO, last two dropped.
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            set_in(20'(i), 20'sd0, 16'd1, 5'd0, 1'b0);
            step();
        end
        sum_valid = 1'b0;
        step();
        step();
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_ovf", 32'(ovf), 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("bp_drain_valid", 32'(out_valid), 32'd1);
            chk("bp_drain_data", 32'(out_data), 32'(i));
            $display("txn bp_drain: out_data=%0d", out_data);
            step();
        end
        chk("bp_empty", 32'(out_valid), 32'd0);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_sat", 32'(sat_cnt), 32'd0);

        // Full FIFO: the fifth write lands on the same edge as the first pop.
        out_ready = 1'b0;
        for (int i = 10; i <= 13; i++) begin
            set_in(20'(i), 20'sd0, 16'd1, 5'd0, 1'b0);
            step();
        end
        sum_valid = 1'b0;
        step();
        step();
        chk("full_head", 32'(out_data), 32'd10);
        set_in(20'sd14, 20'sd0, 16'd1, 5'd0, 1'b0);
        step();
        sum_valid = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        chk("full_ovf", 32'(ovf), 32'd0);
        for (int i = 11; i <= 14; i++) begin
            chk("full_data", 32'(out_data), 32'(i));
            $display("txn full_drain: out_data=%0d", out_data);
            step();
        end
        chk("full_empty", 32'(out_valid), 32'd0);

        // Reset with three buffered results and two in the pipeline.
        out_ready = 1'b0;
        set_in(20'sd1000, 20'sd0, 16'd1, 5'd0, 1'b0);
        step();
        for (int i = 2; i <= 5; i++) begin
            set_in(20'(i), 20'sd0, 16'd1, 5'd0, 1'b0);
            step();
        end
        sum_valid = 1'b0;
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        chk("mid_pre_sat", 32'(sat_cnt), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        chk("mid_rst_sat", 32'(sat_cnt), 32'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_valid", 32'(out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
